// File: rtl/tcb_vip_pkg.sv
// tcb_vip_pkg: shared types and constants for the TCB subordinate memory VIP.
// Holds the back-pressure mode enum, the LFSR polynomial and its step function.
package tcb_vip_pkg;

    typedef enum logic {
        RDY_ALWAYS = 1'b0,
        RDY_LFSR   = 1'b1
    } rdy_mode_t;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] TCB_LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? TCB_LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/tcb_vip_rdy_gen.sv
// tcb_vip_rdy_gen: pseudo-random ready generator built on a 16-bit Galois LFSR.
// Ports: clk, rst (async, active-high), en (1 = LFSR drives rdy), rdy (out).
module tcb_vip_rdy_gen
    import tcb_vip_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rdy
);

    // a zero seed would lock the register at zero forever
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= INIT;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign rdy = en ? lfsr[0] : 1'b1;

endmodule

// File: rtl/tcb_vip_memory.sv
// tcb_vip_memory: TCB subordinate memory model with byte enables, fixed response
// delay DLY, optional LFSR back-pressure and error responses for bad addresses.
// Ports: clk, rst (async, active-high); request tcb_vld/wen/adr/ben/wdt;
//        tcb_rdy (out); response tcb_rdt/tcb_err valid DLY cycles after a transfer.
module tcb_vip_memory
    import tcb_vip_pkg::*;
#(
    parameter int          ABW  = 32,
    parameter int          DBW  = 32,
    parameter int          SLW  = 8,
    parameter int          DLY  = 1,
    parameter int          SIZ  = 4096,
    parameter rdy_mode_t   RDY  = RDY_ALWAYS,
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               tcb_vld,
    input  logic               tcb_wen,
    input  logic [ABW-1:0]     tcb_adr,
    input  logic [DBW/SLW-1:0] tcb_ben,
    input  logic [DBW-1:0]     tcb_wdt,
    output logic               tcb_rdy,
    output logic [DBW-1:0]     tcb_rdt,
    output logic               tcb_err
);

    localparam int BEW = DBW / SLW;
    localparam int MAW = $clog2(SIZ);

    typedef struct packed {
        logic           vld;
        logic           err;
        logic [DBW-1:0] rdt;
    } tcb_rsp_t;

    logic           gen_rdy;
    logic           trn;
    logic           err;
    logic [MAW-1:0] idx;
    logic [DBW-1:0] rdt;
    logic [DBW-1:0] hold_rdt;
    logic           hold_err;
    tcb_rsp_t       req_rsp;
    tcb_rsp_t       tail;

    logic [SLW-1:0] mem [SIZ];

    tcb_vip_rdy_gen #(
        .SEED (SEED)
    ) u_rdy (
        .clk (clk),
        .rst (rst),
        .en  (RDY == RDY_LFSR),
        .rdy (gen_rdy)
    );

    // an idle manager always sees ready, so rdy never gates a non-request
    assign tcb_rdy = gen_rdy | ~tcb_vld;

    // nothing is accepted while reset is held
    assign trn = tcb_vld & tcb_rdy & ~rst;

    assign err = (tcb_adr >= ABW'(SIZ))
               | ((tcb_adr & ABW'(BEW - 1)) != '0);

    assign idx = tcb_adr[MAW-1:0];

    // read is taken from the array before this cycle's write lands
    always_comb begin
        rdt = '0;
        if (!tcb_wen && !err) begin
            for (int i = 0; i < BEW; i++) begin
                if (tcb_ben[i]) begin
                    rdt[i*SLW +: SLW] = mem[idx + MAW'(i)];
                end
            end
        end
    end

    // storage is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (trn && tcb_wen && !err) begin
            for (int i = 0; i < BEW; i++) begin
                if (tcb_ben[i]) begin
                    mem[idx + MAW'(i)] <= tcb_wdt[i*SLW +: SLW];
                end
            end
        end
    end

    assign req_rsp = '{vld: trn, err: err, rdt: rdt};

    generate
        if (DLY == 0) begin : g_comb
            assign tail = req_rsp;
        end else begin : g_pipe
            tcb_rsp_t pipe [DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DLY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= req_rsp;
                    for (int i = 1; i < DLY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tail = pipe[DLY-1];
        end
    endgenerate

    // outputs show the newest response and hold it until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rdt <= '0;
            hold_err <= 1'b0;
        end else if (tail.vld) begin
            hold_rdt <= tail.rdt;
            hold_err <= tail.err;
        end
    end

    assign tcb_rdt = tail.vld ? tail.rdt : hold_rdt;
    assign tcb_err = tail.vld ? tail.err : hold_err;

    // bench-side debug access, not part of the synthesised model
    task automatic mem_load(input logic [MAW-1:0] addr, input logic [SLW-1:0] data);
        mem[addr] <= data;
    endtask

    function automatic logic [SLW-1:0] mem_dump(input logic [MAW-1:0] addr);
        return mem[addr];
    endfunction

endmodule

// File: tb/tb_tcb_vip_memory.sv
// tb_tcb_vip_memory: scoreboard bench for tcb_vip_memory with three instances
// (DLY=1 always-ready, DLY=3 always-ready, DLY=2 LFSR back-pressure).
module tb_tcb_vip_memory;
    import tcb_vip_pkg::*;

    localparam logic [32:0] ERR = 33'h1_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        vld [3];
    logic        wen [3];
    logic [31:0] adr [3];
    logic [3:0]  ben [3];
    logic [31:0] wdt [3];
    logic        rdy [3];
    logic [31:0] rdt [3];
    logic        err [3];

    int total = 0;
    int bad   = 0;
    int vcyc  = 0;
    int lowc  = 0;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];
    logic [7:0]  mdl [4096];
    logic [15:0] lf;

    always #5 clk = ~clk;

    function automatic logic [32:0] ok(input logic [31:0] v);
        return {1'b0, v};
    endfunction

    function automatic void chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endfunction

    function automatic void qpush(input int k, input logic [32:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [32:0] qpop(input int k);
        logic [32:0] v;
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
        return v;
    endfunction

    function automatic void qclr();
        q0.delete();
        q1.delete();
        q2.delete();
    endfunction

    // reference LFSR for the back-pressured instance
    initial begin
        lf = 16'hACE1;
        forever begin
            @(posedge clk);
            if (rst) lf = 16'hACE1;
            else     lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : 2;

        tcb_vip_memory #(
            .ABW  (32),
            .DBW  (32),
            .SLW  (8),
            .DLY  (D),
            .SIZ  (4096),
            .RDY  (rdy_mode_t'(g == 2)),
            .SEED (16'hACE1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tcb_vld (vld[g]),
            .tcb_wen (wen[g]),
            .tcb_adr (adr[g]),
            .tcb_ben (ben[g]),
            .tcb_wdt (wdt[g]),
            .tcb_rdy (rdy[g]),
            .tcb_rdt (rdt[g]),
            .tcb_err (err[g])
        );

        // monitor: a transfer seen now must show its response D cycles later
        initial begin : mon
            logic [4:0] due;
            due = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    due = '0;
                end else begin
                    due = {due[3:0], vld[g] & rdy[g]};
                    if (due[D]) begin
                        if (qsize(g) == 0) begin
                            total++;
                            bad++;
                            $display("FAIL rsp%0d got=%h want=none", g, {err[g], rdt[g]});
                        end else begin
                            chk($sformatf("rsp%0d", g), {err[g], rdt[g]}, qpop(g));
                        end
                    end
                end
            end
        end
    end

    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic [32:0] x, input bit hx);
        logic [32:0] e;
        int n;
        @(posedge clk);
        #1;
        vld[k] = 1'b1;
        wen[k] = w;
        adr[k] = a;
        ben[k] = b;
        wdt[k] = d;
        n = 0;
        forever begin
            @(negedge clk);
            vcyc++;
            if (k == 2) chk("rdy_lfsr", {32'h0, rdy[2]}, {32'h0, lf[0]});
            if (rdy[k]) break;
            lowc++;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL xfer_timeout got=busy want=ready");
                vld[k] = 1'b0;
                return;
            end
        end
        if (hx) begin
            e = x;
        end else begin
            e = '0;
            if (a >= 32'd4096 || a[1:0] != 2'b00) begin
                e[32] = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) begin
                        if (w) mdl[int'(a[11:0]) + i] = d[i*8 +: 8];
                        else   e[i*8 +: 8] = mdl[int'(a[11:0]) + i];
                    end
                end
            end
        end
        qpush(k, e);
    endtask

    task automatic idle(input int k);
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;

        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            wen[k] = 1'b0;
            adr[k] = '0;
            ben[k] = '0;
            wdt[k] = '0;
        end

        // reset values
        vld[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out%0d", k), {err[k], rdt[k]}, 33'h0);
        end
        chk("rst_rdy_always", {32'h0, rdy[0]}, 33'h1);
        chk("rst_rdy_lfsr", {32'h0, rdy[2]}, 33'h1);
        vld[2] = 1'b0;
        rst = 1'b0;

        // DLY=1 directed vectors
        xfer(0, 1'b1, 'h10,  4'hF, 'hDEADBEEF, 33'h0, 1'b1);
        xfer(0, 1'b0, 'h10,  4'hF, 'h0, ok('hDEADBEEF), 1'b1);
        xfer(0, 1'b1, 'h20,  4'hF, 'h11223344, 33'h0, 1'b1);
        xfer(0, 1'b1, 'h24,  4'hF, 'h55667788, 33'h0, 1'b1);
        xfer(0, 1'b1, 'h20,  4'b0101, 'hAABBCCDD, 33'h0, 1'b1);
        xfer(0, 1'b0, 'h20,  4'hF, 'h0, ok('h11BB33DD), 1'b1);
        xfer(0, 1'b0, 'h20,  4'b0110, 'h0, ok('h00BB3300), 1'b1);
        xfer(0, 1'b0, 'h1000, 4'hF, 'h0, ERR, 1'b1);
        xfer(0, 1'b1, 'h22,  4'hF, 'h99999999, ERR, 1'b1);
        xfer(0, 1'b0, 'h20,  4'hF, 'h0, ok('h11BB33DD), 1'b1);
        xfer(0, 1'b0, 'h24,  4'hF, 'h0, ok('h55667788), 1'b1);
        xfer(0, 1'b1, 'h0,   4'hF, 'hCAFEF00D, 33'h0, 1'b1);
        xfer(0, 1'b1, 'h1000, 4'hF, 'h12345678, ERR, 1'b1);
        xfer(0, 1'b0, 'h0,   4'hF, 'h0, ok('hCAFEF00D), 1'b1);
        xfer(0, 1'b1, 'hFFC, 4'hF, 'h01020304, 33'h0, 1'b1);
        xfer(0, 1'b0, 'hFFC, 4'hF, 'h0, ok('h01020304), 1'b1);
        xfer(0, 1'b0, 'h1,   4'hF, 'h0, ERR, 1'b1);
        xfer(0, 1'b0, 'hFFC, 4'b1000, 'h0, ok('h01000000), 1'b1);
        idle(0);

        // DLY=3 back-to-back
        xfer(1, 1'b1, 'h0, 4'hF, 'h10101010, 33'h0, 1'b1);
        xfer(1, 1'b1, 'h4, 4'hF, 'h20202020, 33'h0, 1'b1);
        xfer(1, 1'b1, 'h8, 4'hF, 'h30303030, 33'h0, 1'b1);
        xfer(1, 1'b1, 'hC, 4'hF, 'h40404040, 33'h0, 1'b1);
        xfer(1, 1'b0, 'h0, 4'hF, 'h0, ok('h10101010), 1'b1);
        xfer(1, 1'b0, 'h4, 4'hF, 'h0, ok('h20202020), 1'b1);
        xfer(1, 1'b0, 'h8, 4'hF, 'h0, ok('h30303030), 1'b1);
        xfer(1, 1'b0, 'hC, 4'hF, 'h0, ok('h40404040), 1'b1);
        idle(1);
        repeat (5) @(posedge clk);

        // reset in the middle of a read
        xfer(1, 1'b0, 'h4, 4'hF, 'h0, ok('h20202020), 1'b1);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out1", {err[1], rdt[1]}, 33'h0);
        chk("midrst_out0", {err[0], rdt[0]}, 33'h0);
        qclr();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_quiet", {err[1], rdt[1]}, 33'h0);
        end
        xfer(1, 1'b0, 'h8, 4'hF, 'h0, ok('h30303030), 1'b1);
        idle(1);
        repeat (5) @(posedge clk);

        // LFSR back-pressure against the reference model
        for (int i = 0; i < 64; i++) begin
            xfer(2, 1'b1, 32'(i * 4), 4'hF, $urandom, 33'h0, 1'b0);
        end
        vcyc = 0;
        lowc = 0;
        for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      a = 32'(4096 + 4 * $urandom_range(0, 15));
            else if (r == 1) a = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else             a = 32'(4 * $urandom_range(0, 63));
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            xfer(2, w, a, b, $urandom, 33'h0, 1'b0);
            if ($urandom_range(0, 7) == 0) idle(2);
        end
        idle(2);
        repeat (8) @(negedge clk);

        total++;
        if (vcyc == 0 || lowc * 10 < vcyc * 3 || lowc * 10 > vcyc * 7) begin
            bad++;
            $display("FAIL rdy_low_ratio got=%0d/%0d want=30..70 pct", lowc, vcyc);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d", k), 33'(qsize(k)), 33'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
